// File: rtl/intadd_wb.sv
// Writeback sequencer behind the intadd adder: buffers two results and drains them
// one register per beat. Optional stall counter enabled by INTADD_WB_PERF_EN.
module intadd_wb #(
  parameter int DEPTH = 2,
  parameter int AW    = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           inst_valid,
  output logic           in_ready,
  input  logic [127:0]   dst_reg0,
  input  logic [127:0]   dst_reg1,
  input  logic           dual,
  input  logic [AW-1:0]  waddr0,
  input  logic [AW-1:0]  waddr1,
  output logic           wr_en,
  input  logic           wr_ready,
  output logic [AW-1:0]  wr_addr,
  output logic [127:0]   wr_data,
  output logic           busy,
  output logic [15:0]    stall_cnt
);

  logic [127:0]  d0_q   [DEPTH];
  logic [127:0]  d1_q   [DEPTH];
  logic [AW-1:0] a0_q   [DEPTH];
  logic [AW-1:0] a1_q   [DEPTH];
  logic          dual_q [DEPTH];

  logic       head;
  logic       tail;
  logic [1:0] count;
  logic       beat;

  logic full;
  logic empty;
  logic push;
  logic handshake;
  logic second_beat;
  logic pop;

  assign full        = (count == 2'd2);
  assign empty       = (count == 2'd0);
  assign push        = inst_valid && !full;
  assign handshake   = !empty && wr_ready;
  assign second_beat = !beat && dual_q[head];
  assign pop         = handshake && !second_beat;

  // Outputs decode registered state only; storage is zero at reset so wr_* read 0.
  assign in_ready = !full;
  assign wr_en    = !empty;
  assign busy     = !empty;
  assign wr_addr  = beat ? a1_q[head] : a0_q[head];
  assign wr_data  = beat ? d1_q[head] : d0_q[head];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        d0_q[i]   <= '0;
        d1_q[i]   <= '0;
        a0_q[i]   <= '0;
        a1_q[i]   <= '0;
        dual_q[i] <= 1'b0;
      end
    end else if (push) begin
      d0_q[tail]   <= dst_reg0;
      d1_q[tail]   <= dst_reg1;
      a0_q[tail]   <= waddr0;
      a1_q[tail]   <= waddr1;
      dual_q[tail] <= dual;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= 1'b0;
      tail  <= 1'b0;
      count <= 2'd0;
      beat  <= 1'b0;
    end else begin
      if (push) tail <= ~tail;
      if (handshake) begin
        if (second_beat) begin
          beat <= 1'b1;
        end else begin
          beat <= 1'b0;
          head <= ~head;
        end
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

`ifdef INTADD_WB_PERF_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= 16'h0000;
    end else if (!empty && !wr_ready && stall_q != 16'hFFFF) begin
      stall_q <= stall_q + 16'h0001;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_intadd_wb.sv
// Self-checking bench for intadd_wb: directed scenarios plus a randomized run
// against a queue-based model of buffered results and their beats.
module tb_intadd_wb;
  localparam int AW = 5;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           inst_valid;
  logic           in_ready;
  logic [127:0]   dst_reg0;
  logic [127:0]   dst_reg1;
  logic           dual;
  logic [AW-1:0]  waddr0;
  logic [AW-1:0]  waddr1;
  logic           wr_en;
  logic           wr_ready;
  logic [AW-1:0]  wr_addr;
  logic [127:0]   wr_data;
  logic           busy;
  logic [15:0]    stall_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [127:0]  d0;
    logic [127:0]  d1;
    logic [AW-1:0] a0;
    logic [AW-1:0] a1;
    logic          dual;
  } result_t;

  intadd_wb #(.DEPTH(2), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .inst_valid(inst_valid), .in_ready(in_ready),
    .dst_reg0(dst_reg0), .dst_reg1(dst_reg1), .dual(dual),
    .waddr0(waddr0), .waddr1(waddr1), .wr_en(wr_en), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic do_reset();
    inst_valid = 1'b0; dual = 1'b0; wr_ready = 1'b1;
    dst_reg0 = '0; dst_reg1 = '0; waddr0 = '0; waddr1 = '0;
    rst_n = 1'b0;
    tick();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic drive(input logic v, input logic du, input logic [AW-1:0] a0,
                       input logic [AW-1:0] a1, input logic [127:0] d0, input logic [127:0] d1);
    inst_valid = v; dual = du; waddr0 = a0; waddr1 = a1; dst_reg0 = d0; dst_reg1 = d1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({wr_en, busy, in_ready} !== 3'b001)
      $display("FAIL reset_flags got %b exp 001", {wr_en, busy, in_ready});
    else n_pass++;
    n_checks++;
    if (wr_addr !== '0 || wr_data !== '0 || stall_cnt !== 16'h0)
      $display("FAIL reset_data got addr %h data %h stall %h exp 0", wr_addr, wr_data, stall_cnt);
    else n_pass++;
  endtask

  task automatic test_single();
    do_reset();
    drive(1'b1, 1'b0, 5'd3, 5'd9, 128'hDEADBEEF, 128'h1111);
    tick();
    drive(1'b0, 1'b0, 5'd0, 5'd0, '0, '0);
    n_checks++;
    if (wr_en !== 1'b1 || wr_addr !== 5'd3 || wr_data !== 128'hDEADBEEF)
      $display("FAIL single_beat got en %b addr %0d data %h exp en 1 addr 3 data deadbeef", wr_en, wr_addr, wr_data);
    else n_pass++;
    tick();
    n_checks++;
    if (busy !== 1'b0 || wr_en !== 1'b0)
      $display("FAIL single_drain got busy %b en %b exp 0 0", busy, wr_en);
    else n_pass++;
  endtask

  task automatic test_dual();
    logic [127:0] x, y;
    x = rand128(); y = rand128();
    do_reset();
    drive(1'b1, 1'b1, 5'd4, 5'd5, x, y);
    tick();
    drive(1'b0, 1'b0, 5'd0, 5'd0, '0, '0);
    n_checks++;
    if (wr_en !== 1'b1 || wr_addr !== 5'd4 || wr_data !== x)
      $display("FAIL dual_beat0 got addr %0d data %h exp addr 4 data %h", wr_addr, wr_data, x);
    else n_pass++;
    tick();
    n_checks++;
    if (wr_en !== 1'b1 || wr_addr !== 5'd5 || wr_data !== y)
      $display("FAIL dual_beat1 got addr %0d data %h exp addr 5 data %h", wr_addr, wr_data, y);
    else n_pass++;
    tick();
    n_checks++;
    if (busy !== 1'b0)
      $display("FAIL dual_drain got busy %b exp 0", busy);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [127:0] r1, r2a, r2b, r3;
    r1 = rand128(); r2a = rand128(); r2b = rand128(); r3 = rand128();
    do_reset();
    wr_ready = 1'b0;
    drive(1'b1, 1'b0, 5'd7, 5'd0, r1, '0);
    tick();
    drive(1'b1, 1'b1, 5'd8, 5'd9, r2a, r2b);
    tick();
    n_checks++;
    if (in_ready !== 1'b0 || wr_addr !== 5'd7 || wr_data !== r1)
      $display("FAIL bp_full got rdy %b addr %0d data %h exp rdy 0 addr 7 data %h", in_ready, wr_addr, wr_data, r1);
    else n_pass++;
    drive(1'b1, 1'b0, 5'd12, 5'd0, r3, '0);
    tick();
    tick();
    n_checks++;
    if (in_ready !== 1'b0 || wr_en !== 1'b1 || wr_addr !== 5'd7 || wr_data !== r1)
      $display("FAIL bp_hold got rdy %b en %b addr %0d exp rdy 0 en 1 addr 7", in_ready, wr_en, wr_addr);
    else n_pass++;
    drive(1'b0, 1'b0, 5'd0, 5'd0, '0, '0);
    wr_ready = 1'b1;
    tick();
    n_checks++;
    if (in_ready !== 1'b1 || wr_addr !== 5'd8 || wr_data !== r2a)
      $display("FAIL bp_drain0 got rdy %b addr %0d exp rdy 1 addr 8", in_ready, wr_addr);
    else n_pass++;
    tick();
    n_checks++;
    if (wr_addr !== 5'd9 || wr_data !== r2b)
      $display("FAIL bp_drain1 got addr %0d exp 9", wr_addr);
    else n_pass++;
    tick();
    n_checks++;
    if (wr_en !== 1'b0 || busy !== 1'b0)
      $display("FAIL bp_dropped got en %b addr %0d exp en 0", wr_en, wr_addr);
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    logic [127:0] a, b;
    a = rand128(); b = rand128();
    do_reset();
    drive(1'b1, 1'b0, 5'd1, 5'd0, a, '0);
    tick();
    drive(1'b1, 1'b0, 5'd2, 5'd0, b, '0);
    n_checks++;
    if (wr_addr !== 5'd1 || wr_data !== a)
      $display("FAIL simul_first got addr %0d exp 1", wr_addr);
    else n_pass++;
    tick();
    drive(1'b0, 1'b0, 5'd0, 5'd0, '0, '0);
    n_checks++;
    if (wr_en !== 1'b1 || in_ready !== 1'b1 || wr_addr !== 5'd2 || wr_data !== b)
      $display("FAIL simul_second got en %b rdy %b addr %0d exp 1 1 2", wr_en, in_ready, wr_addr);
    else n_pass++;
    tick();
    n_checks++;
    if (busy !== 1'b0)
      $display("FAIL simul_drain got busy %b exp 0", busy);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    do_reset();
    drive(1'b1, 1'b1, 5'd10, 5'd11, rand128(), rand128());
    tick();
    drive(1'b0, 1'b0, 5'd0, 5'd0, '0, '0);
    tick();
    n_checks++;
    if (wr_addr !== 5'd11)
      $display("FAIL arst_beat1 got addr %0d exp 11", wr_addr);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({wr_en, busy, in_ready} !== 3'b001)
      $display("FAIL arst_immediate got en/busy/rdy %b exp 001", {wr_en, busy, in_ready});
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (wr_en !== 1'b0)
        $display("FAIL arst_after got en %b exp 0 (cycle %0d)", wr_en, i);
      else n_pass++;
    end
  endtask

  task automatic test_perf();
    logic [15:0] exp_cnt;
    do_reset();
    wr_ready = 1'b0;
    drive(1'b1, 1'b0, 5'd6, 5'd0, rand128(), '0);
    tick();
    drive(1'b0, 1'b0, 5'd0, 5'd0, '0, '0);
    for (int i = 0; i < 10; i++) tick();
`ifdef INTADD_WB_PERF_EN
    exp_cnt = 16'd10;
`else
    exp_cnt = 16'd0;
`endif
    n_checks++;
    if (stall_cnt !== exp_cnt)
      $display("FAIL perf_stall got %0d exp %0d", stall_cnt, exp_cnt);
    else n_pass++;
    wr_ready = 1'b1;
    tick();
  endtask

  task automatic test_random();
    result_t q[$];
    result_t r;
    int      sub;
    int      stalls;
    logic    push, hs;
    logic [AW-1:0] ea;
    logic [127:0]  ed;
    do_reset();
    sub = 0;
    stalls = 0;
    for (int c = 0; c < 400; c++) begin
      r.d0 = rand128(); r.d1 = rand128();
      r.a0 = AW'($urandom); r.a1 = AW'($urandom);
      r.dual = 1'($urandom);
      drive(1'($urandom_range(0, 2) != 0), r.dual, r.a0, r.a1, r.d0, r.d1);
      wr_ready = ($urandom_range(0, 3) != 0);
      push = inst_valid && (q.size() < 2);
      hs   = (q.size() > 0) && wr_ready;
      if (q.size() > 0 && !wr_ready && stalls < 65535) stalls++;
      tick();
      if (hs) begin
        if (sub == 0 && q[0].dual) sub = 1;
        else begin
          void'(q.pop_front());
          sub = 0;
        end
      end
      if (push) q.push_back(r);
      n_checks++;
      if (wr_en !== (q.size() > 0) || busy !== (q.size() > 0) || in_ready !== (q.size() < 2))
        $display("FAIL rand_flags c%0d got en %b busy %b rdy %b exp size %0d", c, wr_en, busy, in_ready, q.size());
      else n_pass++;
      if (q.size() > 0) begin
        ea = (sub == 1) ? q[0].a1 : q[0].a0;
        ed = (sub == 1) ? q[0].d1 : q[0].d0;
        n_checks++;
        if (wr_addr !== ea || wr_data !== ed)
          $display("FAIL rand_beat c%0d got addr %0d data %h exp addr %0d data %h", c, wr_addr, wr_data, ea, ed);
        else n_pass++;
      end
    end
`ifndef INTADD_WB_PERF_EN
    stalls = 0;
`endif
    n_checks++;
    if (stall_cnt !== 16'(stalls))
      $display("FAIL rand_stall got %0d exp %0d", stall_cnt, stalls);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_dual();
    test_backpressure();
    test_simultaneous();
    test_async_reset();
    test_perf();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
